// File: rtl/multicycle_control_fsm.sv
// Main control for a shared-memory multicycle RV32I datapath.
// Moore FSM with registered state-decoded controls; MemReady and BranchTaken
// gate the IRWrite/PCWrite strobes combinationally so FETCH and BRANCH
// complete in the cycle the condition arrives.
// Includes a memory-wait watchdog (MEM_TIMEOUT = 0 disables it) and a
// retired-instruction counter.
// Optional build macro ILLEGAL_TRAP_EN: unrecognised opcodes trap into a
// sticky TRAP state and raise IllegalInstr. Without it they retire as NOPs
// (no retire pulse) and the IllegalInstr port does not exist.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int TMO_CNT_W    = 8,
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              Op,
  input  logic                    MemReady,
  input  logic                    BranchTaken,
  output logic                    MemReq,
  output logic                    MemWrite,
  output logic                    AdrSrc,
  output logic                    IRWrite,
  output logic                    PCWrite,
  output logic                    RegWrite,
  output logic [1:0]              ResultSrc,
  output logic [1:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [1:0]              ALUOp,
  output logic [2:0]              ImmSrc,
  output logic                    InstrRetired,
  output logic [RETIRE_CNT_W-1:0] RetireCount,
`ifdef ILLEGAL_TRAP_EN
  output logic                    IllegalInstr,
`endif
  output logic                    MemFault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam bit                   WD_EN    = (MEM_TIMEOUT > 0);
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(WD_EN ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [4:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, LUI, AUIPC, ALUWB, JAL, JALR_TGT, JALR_JUMP,
    BRANCH, FAULT, TRAP
  } state_t;

  // Registered control word; pc_fetch is qualified by MemReady, branch by BranchTaken.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_fetch;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       imm_en;
  } ctl_t;

  state_t               state, nxt;
  ctl_t                 ctl;
  logic [TMO_CNT_W-1:0] tmo_cnt;
  logic                 timeout;
  logic                 mem_wait;
  logic                 retire_nxt;
  logic [2:0]           imm_dec;
  logic                 fault_q;
`ifdef ILLEGAL_TRAP_EN
  logic                 illegal_q;
`endif

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    c.imm_en = !(s inside {IDLE, FAULT, TRAP});
    case (s)
      FETCH: begin
        c.mem_req = 1'b1; c.ir_write = 1'b1; c.pc_fetch = 1'b1;
        c.result_src = 2'b10; c.alu_src_b = 2'b10;
      end
      DECODE:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:   begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      MEMWB:     begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE:  begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
      EXECR:     begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECI:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      LUI:       begin c.alu_src_b = 2'b01; c.alu_op = 2'b11; end
      AUIPC:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      ALUWB:     begin c.reg_write = 1'b1; end
      JAL, JALR_JUMP: begin
        c.pc_update = 1'b1; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10;
      end
      JALR_TGT:  begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      BRANCH:    begin c.branch = 1'b1; c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
      default:   ;
    endcase
    return c;
  endfunction

  // Next-state selection, including watchdog expiry in the memory-wait states.
  always_comb begin
    mem_wait = state inside {FETCH, MEMREAD, MEMWRITE};
    timeout  = WD_EN && mem_wait && !MemReady && (tmo_cnt == TMO_LAST);
    nxt      = state;
    case (state)
      IDLE:     nxt = FETCH;
      FETCH:    if (MemReady) nxt = DECODE; else if (timeout) nxt = FAULT;
      DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: nxt = MEMADR;
          OP_R:              nxt = EXECR;
          OP_I:              nxt = EXECI;
          OP_JAL:            nxt = JAL;
          OP_JALR:           nxt = JALR_TGT;
          OP_BR:             nxt = BRANCH;
          OP_LUI:            nxt = LUI;
          OP_AUIPC:          nxt = AUIPC;
`ifdef ILLEGAL_TRAP_EN
          default:           nxt = TRAP;
`else
          default:           nxt = FETCH;
`endif
        endcase
      end
      MEMADR:   nxt = (Op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (MemReady) nxt = MEMWB; else if (timeout) nxt = FAULT;
      MEMWB:    nxt = FETCH;
      MEMWRITE: if (MemReady) nxt = FETCH; else if (timeout) nxt = FAULT;
      EXECR, EXECI, LUI, AUIPC, JAL, JALR_JUMP: nxt = ALUWB;
      ALUWB:    nxt = FETCH;
      JALR_TGT: nxt = JALR_JUMP;
      BRANCH:   nxt = FETCH;
      FAULT:    nxt = FAULT;
      TRAP:     nxt = TRAP;
      default:  nxt = IDLE;
    endcase
    retire_nxt = (nxt == FETCH) && (state inside {MEMWB, MEMWRITE, ALUWB, BRANCH});
  end

  // Immediate format follows the opcode in every active state.
  always_comb begin
    case (Op)
      OP_LOAD, OP_I, OP_JALR: imm_dec = 3'b000;
      OP_STORE:               imm_dec = 3'b001;
      OP_BR:                  imm_dec = 3'b010;
      OP_JAL:                 imm_dec = 3'b011;
      OP_LUI, OP_AUIPC:       imm_dec = 3'b100;
      default:                imm_dec = 3'b000;
    endcase
  end

  // State, registered controls, watchdog, retire counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ctl          <= '0;
      tmo_cnt      <= '0;
      InstrRetired <= 1'b0;
      RetireCount  <= '0;
      fault_q      <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q    <= 1'b0;
`endif
    end else begin
      state        <= nxt;
      ctl          <= decode(nxt);
      InstrRetired <= retire_nxt;
      if (retire_nxt) RetireCount <= RetireCount + 1'b1;
      if (nxt != state && (nxt inside {FETCH, MEMREAD, MEMWRITE}))
        tmo_cnt <= '0;
      else if (mem_wait && !MemReady)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (nxt == FAULT) fault_q <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
      if (nxt == TRAP) illegal_q <= 1'b1;
`endif
    end
  end

  assign MemReq    = ctl.mem_req;
  assign MemWrite  = ctl.mem_write;
  assign AdrSrc    = ctl.adr_src;
  assign IRWrite   = ctl.ir_write & MemReady;
  assign PCWrite   = (ctl.pc_fetch & MemReady) | ctl.pc_update | (ctl.branch & BranchTaken);
  assign RegWrite  = ctl.reg_write;
  assign ResultSrc = ctl.result_src;
  assign ALUSrcA   = ctl.alu_src_a;
  assign ALUSrcB   = ctl.alu_src_b;
  assign ALUOp     = ctl.alu_op;
  assign ImmSrc    = ctl.imm_en ? imm_dec : 3'b000;
  assign MemFault  = fault_q;
`ifdef ILLEGAL_TRAP_EN
  assign IllegalInstr = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (MEM_TIMEOUT=16, RETIRE_CNT_W=4).
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Op = 7'b0110011;
  logic       MemReady = 1'b0;
  logic       BranchTaken = 1'b0;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       InstrRetired, MemFault;
  logic [3:0] RetireCount;
`ifdef ILLEGAL_TRAP_EN
  logic       IllegalInstr;
`endif

  int checks = 0;
  int fails  = 0;
  int rw_cnt;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(16), .TMO_CNT_W(8), .RETIRE_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .MemReady(MemReady), .BranchTaken(BranchTaken),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .InstrRetired(InstrRetired),
    .RetireCount(RetireCount),
`ifdef ILLEGAL_TRAP_EN
    .IllegalInstr(IllegalInstr),
`endif
    .MemFault(MemFault)
  );

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  logic [13:0] obs;
  assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

  localparam logic [13:0] E_ZERO   = 14'b0;
  localparam logic [13:0] E_F_RDY  = {6'b100110, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [13:0] E_F_WAIT = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [13:0] E_DECODE = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00};
  localparam logic [13:0] E_MEMADR = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00};
  localparam logic [13:0] E_MEMRD  = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] E_MEMWB  = {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] E_EXECR  = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10};
  localparam logic [13:0] E_ALUWB  = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [13:0] E_JALRJ  = {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00};
  localparam logic [13:0] E_BR_T   = {6'b000010, 2'b00, 2'b10, 2'b00, 2'b01};
  localparam logic [13:0] E_BR_N   = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b01};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the DUT in its first FETCH cycle with counters cleared.
  task automatic reset_dut();
    rst_n = 1'b0; MemReady = 1'b0; BranchTaken = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; MemReady = 1'b1; Op = 7'b0110011; #1;
    checks++; if (obs !== E_ZERO) begin fails++; $display("FAIL reset_outs: got %b want %b", obs, E_ZERO); end
    checks++; if ({RetireCount, InstrRetired, MemFault, ImmSrc} !== 9'b0) begin
      fails++; $display("FAIL reset_cnt: got cnt=%0d ret=%b flt=%b imm=%b want 0", RetireCount, InstrRetired, MemFault, ImmSrc); end
    tick();
    rst_n = 1'b1; #1;
    checks++; if (obs !== E_ZERO) begin fails++; $display("FAIL idle_outs: got %b want %b", obs, E_ZERO); end
    tick();
    checks++; if (obs !== E_F_RDY) begin fails++; $display("FAIL fetch_first: got %b want %b", obs, E_F_RDY); end
  endtask

  task automatic test_load();
    reset_dut();
    Op = 7'b0000011; rw_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1; rw_cnt += int'(RegWrite);
      checks++; if (obs !== E_F_WAIT) begin fails++; $display("FAIL ld_fetch_wait%0d: got %b want %b", i, obs, E_F_WAIT); end
      tick();
    end
    MemReady = 1'b1; #1;
    checks++; if (obs !== E_F_RDY) begin fails++; $display("FAIL ld_fetch_rdy: got %b want %b", obs, E_F_RDY); end
    tick(); MemReady = 1'b0; #1; rw_cnt += int'(RegWrite);
    checks++; if (obs !== E_DECODE) begin fails++; $display("FAIL ld_decode: got %b want %b", obs, E_DECODE); end
    tick(); rw_cnt += int'(RegWrite);
    checks++; if (obs !== E_MEMADR) begin fails++; $display("FAIL ld_memadr: got %b want %b", obs, E_MEMADR); end
    tick();
    for (int i = 0; i < 4; i++) begin
      MemReady = (i == 3); #1; rw_cnt += int'(RegWrite);
      checks++; if (obs !== E_MEMRD) begin fails++; $display("FAIL ld_memread%0d: got %b want %b", i, obs, E_MEMRD); end
      tick();
    end
    MemReady = 1'b0; #1; rw_cnt += int'(RegWrite);
    checks++; if (obs !== E_MEMWB) begin fails++; $display("FAIL ld_memwb: got %b want %b", obs, E_MEMWB); end
    tick(); rw_cnt += int'(RegWrite);
    checks++; if ({InstrRetired, RetireCount} !== 5'b1_0001) begin
      fails++; $display("FAIL ld_retire: got ret=%b cnt=%0d want ret=1 cnt=1", InstrRetired, RetireCount); end
    checks++; if (obs !== E_F_WAIT) begin fails++; $display("FAIL ld_back_fetch: got %b want %b", obs, E_F_WAIT); end
    tick();
    checks++; if (InstrRetired !== 1'b0) begin fails++; $display("FAIL ld_pulse_len: got %b want 0", InstrRetired); end
    checks++; if (rw_cnt != 1) begin fails++; $display("FAIL ld_regwrite_cnt: got %0d want 1", rw_cnt); end
  endtask

  task automatic test_branch();
    reset_dut();
    Op = 7'b1100011; MemReady = 1'b1; #1;
    checks++; if (ImmSrc !== 3'b010) begin fails++; $display("FAIL br_immsrc: got %b want 010", ImmSrc); end
    tick(); MemReady = 1'b0; BranchTaken = 1'b1; #1;
    checks++; if (obs !== E_DECODE) begin fails++; $display("FAIL br_decode: got %b want %b", obs, E_DECODE); end
    tick();
    checks++; if (obs !== E_BR_T) begin fails++; $display("FAIL br_taken: got %b want %b", obs, E_BR_T); end
    BranchTaken = 1'b0; #1;
    checks++; if (obs !== E_BR_N) begin fails++; $display("FAIL br_comb_drop: got %b want %b", obs, E_BR_N); end
    BranchTaken = 1'b1;
    tick();
    checks++; if ({InstrRetired, RetireCount} !== 5'b1_0001) begin
      fails++; $display("FAIL br_retire1: got ret=%b cnt=%0d want ret=1 cnt=1", InstrRetired, RetireCount); end
    MemReady = 1'b1; BranchTaken = 1'b0;
    tick(); MemReady = 1'b0;
    tick();
    checks++; if (obs !== E_BR_N) begin fails++; $display("FAIL br_not_taken: got %b want %b", obs, E_BR_N); end
    tick();
    checks++; if (RetireCount !== 4'd2) begin fails++; $display("FAIL br_retire2: got %0d want 2", RetireCount); end
  endtask

  task automatic test_jalr();
    reset_dut();
    Op = 7'b1100111; MemReady = 1'b1;
    tick(); MemReady = 1'b0;
    tick();
    checks++; if ({obs, ImmSrc} !== {E_MEMADR, 3'b000}) begin fails++; $display("FAIL jalr_tgt: got %b/%b want %b/000", obs, ImmSrc, E_MEMADR); end
    tick();
    checks++; if ({obs, ImmSrc} !== {E_JALRJ, 3'b000}) begin fails++; $display("FAIL jalr_jump: got %b/%b want %b/000", obs, ImmSrc, E_JALRJ); end
    tick();
    checks++; if ({obs, ImmSrc} !== {E_ALUWB, 3'b000}) begin fails++; $display("FAIL jalr_aluwb: got %b/%b want %b/000", obs, ImmSrc, E_ALUWB); end
    tick();
    checks++; if (InstrRetired !== 1'b1) begin fails++; $display("FAIL jalr_retire: got %b want 1", InstrRetired); end
  endtask

  task automatic test_timeout();
    reset_dut();
    Op = 7'b0110011;
    repeat (15) tick();
    checks++; if ({MemReq, MemFault} !== 2'b10) begin fails++; $display("FAIL tmo_cycle16: got req=%b flt=%b want 1/0", MemReq, MemFault); end
    tick();
    checks++; if ({obs, ImmSrc, MemFault} !== {14'b0, 3'b0, 1'b1}) begin
      fails++; $display("FAIL tmo_fault: got %b imm=%b flt=%b want 0 / flt=1", obs, ImmSrc, MemFault); end
    MemReady = 1'b1;
    repeat (3) tick();
    checks++; if ({obs, MemFault} !== {14'b0, 1'b1}) begin fails++; $display("FAIL tmo_sticky: got %b flt=%b want 0 flt=1", obs, MemFault); end
    reset_dut();
    checks++; if (MemFault !== 1'b0) begin fails++; $display("FAIL tmo_reset_clr: got %b want 0", MemFault); end
    repeat (15) tick();
    MemReady = 1'b1; #1;
    checks++; if (IRWrite !== 1'b1) begin fails++; $display("FAIL tmo_limit_ready: got %b want 1", IRWrite); end
    tick(); MemReady = 1'b0; #1;
    checks++; if ({obs, MemFault} !== {E_DECODE, 1'b0}) begin fails++; $display("FAIL tmo_no_fault: got %b flt=%b want %b flt=0", obs, MemFault, E_DECODE); end
    reset_dut();
    repeat (2) tick();
    rst_n = 1'b0; #1;
    checks++; if (MemReq !== 1'b0) begin fails++; $display("FAIL async_rst_memreq: got %b want 0", MemReq); end
  endtask

  task automatic test_retire_wrap();
    reset_dut();
    Op = 7'b0110011;
    for (int i = 0; i < 17; i++) begin
      MemReady = 1'b1; tick(); MemReady = 1'b0;
      tick();
      if (i == 0) begin
        checks++; if (obs !== E_EXECR) begin fails++; $display("FAIL wrap_execr: got %b want %b", obs, E_EXECR); end
      end
      tick(); tick();
      if (i == 15) begin
        checks++; if (RetireCount !== 4'd0) begin fails++; $display("FAIL wrap_16: got %0d want 0", RetireCount); end
      end
    end
    checks++; if (RetireCount !== 4'd1) begin fails++; $display("FAIL wrap_17: got %0d want 1", RetireCount); end
  endtask

  task automatic test_illegal();
    reset_dut();
    Op = 7'b1111111; MemReady = 1'b1;
    tick(); MemReady = 1'b0; #1;
    checks++; if (ImmSrc !== 3'b000) begin fails++; $display("FAIL ill_immsrc: got %b want 000", ImmSrc); end
    tick();
`ifdef ILLEGAL_TRAP_EN
    checks++; if ({obs, IllegalInstr} !== {14'b0, 1'b1}) begin fails++; $display("FAIL ill_trap: got %b ill=%b want 0 ill=1", obs, IllegalInstr); end
`else
    checks++; if (obs !== E_F_WAIT) begin fails++; $display("FAIL ill_nop_fetch: got %b want %b", obs, E_F_WAIT); end
    checks++; if ({InstrRetired, RetireCount} !== 5'b0) begin
      fails++; $display("FAIL ill_no_retire: got ret=%b cnt=%0d want 0/0", InstrRetired, RetireCount); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_branch();
    test_jalr();
    test_timeout();
    test_retire_wrap();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish want finish before 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
